// File: rtl/lmult_arbiter_if.sv
// lmult_arbiter_if: requester-side handshake/operands and shared L_mult port of the arbiter.
interface lmult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DW = 16
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ovf_clr;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] ovf_sticky;
  logic [NUM_REQ*DW-1:0] a_in;
  logic [NUM_REQ*DW-1:0] b_in;
  logic [2*DW-1:0] product_out;
  logic [2*DW-1:0] mult_product;
  logic overflow_out;
  logic mult_overflow;
  logic busy;
  logic [DW-1:0] mult_a;
  logic [DW-1:0] mult_b;
  modport master (
    output req, a_in, b_in, ovf_clr, mult_product, mult_overflow,
    input  grant, done, product_out, overflow_out, ovf_sticky, busy, mult_a, mult_b
  );
  modport slave (
    input  req, a_in, b_in, ovf_clr, mult_product, mult_overflow,
    output grant, done, product_out, overflow_out, ovf_sticky, busy, mult_a, mult_b
  );
endinterface

// File: rtl/lmult_arbiter.sv
// lmult_arbiter: round-robin sharing of one combinational L_mult among NUM_REQ requesters.
module lmult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW = 16
) (
  input logic clock,
  input logic reset,
  lmult_arbiter_if.slave bus
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] rr_ptr, win, w;
  logic [NUM_REQ-1:0] win_oh, w_oh, set_vec;
  int idx;
  // scan downward so the lowest offset from rr_ptr is the last (winning) assignment
  always_comb begin
    win = rr_ptr;
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      idx = idx >= NUM_REQ ? idx - NUM_REQ : idx;
      win = bus.req[PW'(idx)] ? PW'(idx) : win;
    end
  end
  always_comb begin
    win_oh = NUM_REQ'(1) << win;
    w_oh = NUM_REQ'(1) << w;
    set_vec = (state == MULT && bus.mult_overflow) ? w_oh : '0;
    state_nxt = state == IDLE ? (|bus.req ? MULT : IDLE) : state == MULT ? DONE : IDLE;
  end
  assign bus.busy = state != IDLE;
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // set beats a simultaneous clear because set_vec is ORed in after masking
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rr_ptr <= '0;
      w <= '0;
      bus.grant <= '0;
      bus.done <= '0;
      bus.ovf_sticky <= '0;
      bus.product_out <= '0;
      bus.overflow_out <= 1'b0;
      bus.mult_a <= '0;
      bus.mult_b <= '0;
    end else begin
      bus.ovf_sticky <= (bus.ovf_sticky & ~bus.ovf_clr) | set_vec;
      case (state)
        IDLE:
          if (|bus.req) begin
            w <= win;
            bus.grant <= win_oh;
            bus.mult_a <= bus.a_in[int'(win)*DW +: DW];
            bus.mult_b <= bus.b_in[int'(win)*DW +: DW];
          end
        MULT: begin
          bus.product_out <= bus.mult_product;
          bus.overflow_out <= bus.mult_overflow;
          bus.done <= w_oh;
        end
        DONE: begin
          bus.done <= '0;
          bus.grant <= '0;
          rr_ptr <= (w == PW'(NUM_REQ - 1)) ? '0 : w + 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: doc/lmult_arbiter.md
Name: lmult_arbiter

Overview:
- Shares one combinational L_mult instance (16x16 fractional multiply with saturation) among NUM_REQ requesting datapath blocks, e.g. the autocorrelation, LPC and pitch-search FSMs.
- Performs round-robin arbitration, operand muxing and result capture, and returns a one-cycle done strobe to the granted requester.
- Keeps a per-requester sticky overflow flag, matching the global Overflow semantics of the basic-op library.
- Sits between the requester FSMs and the single shared L_mult.

Parameters:
NUM_REQ, 4, number of requesters; the round-robin pointer is clog2(NUM_REQ) bits wide.
DW, 16, operand width; the product is 2*DW bits.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
req  in  NUM_REQ  request per requester; held high until done is seen.
a_in  in  NUM_REQ*DW  flattened operand A; requester i uses bits [i*DW +: DW].
b_in  in  NUM_REQ*DW  flattened operand B, same packing as a_in.
ovf_clr  in  NUM_REQ  clear pulse for sticky overflow i.
grant  out  NUM_REQ  one-hot grant, registered.
done  out  NUM_REQ  one-hot result strobe, one cycle, registered.
product_out  out  2*DW  last captured L_mult product.
overflow_out  out  1  overflow of the last captured operation.
ovf_sticky  out  NUM_REQ  sticky overflow per requester.
busy  out  1  high when state is not IDLE.
mult_a  out  DW  registered operand A to L_mult.
mult_b  out  DW  registered operand B to L_mult.
mult_product  in  2*DW  L_mult product (combinational).
mult_overflow  in  1  L_mult overflow (combinational).

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; rr_ptr=0.
  - grant, done, ovf_sticky, product_out, overflow_out, mult_a and mult_b all go to 0.
  - Applies mid-operation too: any in-flight operation is discarded with no done.
- FSM states: IDLE, MULT, DONE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise choose the winner w as the first set req bit scanning from rr_ptr upward, modulo NUM_REQ.
  - At the clock edge: mult_a<=a_in[w], mult_b<=b_in[w], grant<=onehot(w), go to MULT.
- MULT:
  - The L_mult output settles combinationally.
  - At the clock edge: product_out<=mult_product, overflow_out<=mult_overflow, done<=onehot(w).
  - If mult_overflow, set ovf_sticky[w]. Go to DONE.
- DONE:
  - done is high for this cycle only; grant is still high.
  - At the clock edge: done<=0, grant<=0, rr_ptr<=(w+1) mod NUM_REQ, go to IDLE.
- Latency and throughput:
  - A request sampled in IDLE at edge k gives grant high at k+1 and done high at k+2.
  - One operation completes every 3 cycles.
- Requester rules:
  - Operands need only be valid on the IDLE cycle in which grant is issued.
  - Operands are latched, so a requester may change them once grant is seen.
  - A requester must drop req on the edge where it samples done=1. A req still high in the following IDLE is treated as a new request.
- Request timing:
  - Deasserting req while in MULT or DONE has no effect; the operation completes and done is still pulsed.
  - req changes are only examined in IDLE.
- product_out and overflow_out hold their values until the next MULT capture.
- Fairness: the requester just served gets lowest priority next. With all req high, service order is 0,1,2,3,0,...
- ovf_sticky[i] rules:
  - Set by an overflow on i's operation.
  - Cleared by ovf_clr[i].
  - If set and clear occur on the same edge, set wins.
  - ovf_clr accepted in any state.
- Widths: the product is full 2*DW. No arithmetic is performed in this block; saturation is owned by L_mult.
- busy = (state != IDLE), combinational from the state register.

Test Plan:
- Reset, then req=0001, a0=0x4000, b0=0x4000 -> grant=0001 at +1 cycle; done=0001 at +2; product_out=0x20000000, overflow_out=0, ovf_sticky=0000.
- req=0100, a2=0x8000, b2=0x8000 -> product_out=0x7FFFFFFF, overflow_out=1, ovf_sticky=0100. Then ovf_clr=0100 in the same cycle as a new overflowing op on requester 2 -> ovf_sticky[2] stays 1.
- req=1111 held continuously (each requester re-raises req after its done) -> done order 0001, 0010, 0100, 1000, 0001, with a 3-cycle spacing between consecutive done pulses.
- rr_ptr=2 after serving requester 1; then req=0011 -> requester 0 granted first, then requester 1.
- reset asserted during MULT for requester 3 -> grant and done immediately 0, no done pulse. After release, req=1000 is served normally with rr_ptr starting from 0.
- Operand change after grant (a1 switched 0x1234->0x7FFF during MULT) -> product reflects the latched 0x1234; req dropped during MULT -> done is still pulsed.
